// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and helpers for the performance counter bank
package perf_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1,
    DUMP   = 2'd2
  } state_t;

  // Width of a dump index covering every event channel plus the cycle counter.
  function automatic int idx_w(input int num_evt);
    return $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/perf_ctr.sv
// rtl/perf_ctr.sv - single event counter with saturate/wrap mode and sticky overflow
module perf_ctr #(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // Count on inc; an increment from all-ones flags overflow and then holds or wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf   <= 1'b1;
        count <= SAT ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event/cycle counter bank frozen on halt and dumped over valid/ready
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 32,
  parameter bit SAT     = 1'b1,
  localparam int IDX_W  = idx_w(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  input  logic               dump_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [CNT_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               frozen,
  output logic               dump_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);

  state_t             state;
  logic               cnt_en;
  logic [NUM_EVT:0]   inc;
  logic [CNT_W-1:0]   cnt [NUM_EVT+1];
  logic [NUM_EVT:0]   ovf;
  logic [IDX_W-1:0]   nxt_idx;

  // Counting only happens in RUN; the halt cycle itself is still counted.
  assign cnt_en  = (state == RUN) && en;
  assign inc     = {cnt_en, evt & {NUM_EVT{cnt_en}}};
  assign nxt_idx = out_idx + 1'b1;

  // One counter per event channel, the last entry is the cycle counter.
  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_ctr
    perf_ctr #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc[i]),
      .count (cnt[i]),
      .ovf   (ovf[i])
    );
  end

  // Bank FSM; out_idx doubles as the dump index and every output is registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      frozen    <= 1'b0;
      dump_done <= 1'b0;
    end else if (clr) begin
      state     <= RUN;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      frozen    <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        RUN: begin
          if (halt) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (dump_start) begin
            state     <= DUMP;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_data  <= cnt[0];
            out_ovf   <= ovf[0];
          end
        end
        DUMP: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= FROZEN;
              out_valid <= 1'b0;
              dump_done <= 1'b1;
            end else begin
              out_idx  <= nxt_idx;
              out_data <= cnt[nxt_idx];
              out_ovf  <= ovf[nxt_idx];
            end
          end
        end
        default: begin
          state     <= RUN;
          out_valid <= 1'b0;
          frozen    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - randomized self-checking bench against a behavioural bank model
module tb_perf_counter_bank;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IW   = 3;
  localparam int MAXV = (1 << W) - 1;
  localparam int M_RUN    = 0;
  localparam int M_FROZEN = 1;
  localparam int M_DUMP   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, halt = 1'b0, clr = 1'b0, dump_start = 1'b0, out_ready = 1'b0;
  logic [N-1:0]  evt = '0;

  logic          out_valid_s, out_ovf_s, frozen_s, dump_done_s;
  logic [IW-1:0] out_idx_s;
  logic [W-1:0]  out_data_s;
  logic          out_valid_w, out_ovf_w, frozen_w, dump_done_w;
  logic [IW-1:0] out_idx_w;
  logic [W-1:0]  out_data_w;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_EVT(N), .CNT_W(W), .SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
    .dump_start(dump_start), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_idx(out_idx_s), .out_data(out_data_s), .out_ovf(out_ovf_s),
    .frozen(frozen_s), .dump_done(dump_done_s)
  );

  perf_counter_bank #(.NUM_EVT(N), .CNT_W(W), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
    .dump_start(dump_start), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_idx(out_idx_w), .out_data(out_data_w), .out_ovf(out_ovf_w),
    .frozen(frozen_w), .dump_done(dump_done_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: plain integer counts per entry for both overflow modes.
  int m_s [N+1];
  int m_w [N+1];
  bit m_ovf [N+1];
  int m_mode = M_RUN;
  int m_pos  = 0;
  bit m_done = 1'b0;
  int done_cnt = 0;
  int seen_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i <= N; i++) begin
      m_s[i] = 0;
      m_w[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_mode = M_RUN;
    m_pos  = 0;
    m_done = 1'b0;
  endfunction

  function automatic void bump(input int i);
    if (m_s[i] == MAXV) m_ovf[i] = 1'b1;
    m_s[i] = (m_s[i] == MAXV) ? MAXV : m_s[i] + 1;
    m_w[i] = (m_w[i] + 1) % (MAXV + 1);
  endfunction

  function automatic void model_step(input bit e, input bit [N-1:0] ev, input bit h,
                                     input bit c, input bit ds, input bit rdy);
    m_done = 1'b0;
    if (c) begin
      model_clear();
    end else if (m_mode == M_RUN) begin
      if (e) begin
        for (int i = 0; i < N; i++) if (ev[i]) bump(i);
        bump(N);
      end
      if (h) m_mode = M_FROZEN;
    end else if (m_mode == M_FROZEN) begin
      if (ds) begin
        m_mode = M_DUMP;
        m_pos  = 0;
      end
    end else if (rdy) begin
      if (m_pos == N) begin
        m_mode = M_FROZEN;
        m_done = 1'b1;
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic check_outputs();
    check("frozen_s", frozen_s, m_mode != M_RUN);
    check("frozen_w", frozen_w, m_mode != M_RUN);
    check("valid_s", out_valid_s, m_mode == M_DUMP);
    check("valid_w", out_valid_w, m_mode == M_DUMP);
    check("done_s", dump_done_s, m_done);
    check("done_w", dump_done_w, m_done);
    if (m_mode == M_DUMP) begin
      check("idx_s", out_idx_s, m_pos);
      check("idx_w", out_idx_w, m_pos);
      check("data_s", out_data_s, m_s[m_pos]);
      check("data_w", out_data_w, m_w[m_pos]);
      check("ovf_s", out_ovf_s, m_ovf[m_pos]);
      check("ovf_w", out_ovf_w, m_ovf[m_pos]);
    end
  endtask

  task automatic cycle(input bit e, input bit [N-1:0] ev, input bit h,
                       input bit c, input bit ds, input bit rdy);
    @(negedge clk);
    rst = 1'b1; en = e; evt = ev; halt = h; clr = c; dump_start = ds; out_ready = rdy;
    if (out_valid_s && rdy) seen_q.push_back(int'(out_idx_s));
    @(posedge clk);
    model_step(e, ev, h, c, ds, rdy);
    #1;
    check_outputs();
    if (dump_done_s) done_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; evt = '0; halt = 1'b0; clr = 1'b0; dump_start = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    check("rst_valid", {out_valid_s, out_valid_w}, 2'b00);
    check("rst_idx", {out_idx_s, out_idx_w}, '0);
    check("rst_data", {out_data_s, out_data_w}, '0);
    check("rst_ovf", {out_ovf_s, out_ovf_w}, 2'b00);
    check("rst_frozen", {frozen_s, frozen_w}, 2'b00);
    check("rst_done", {dump_done_s, dump_done_w}, 2'b00);
  endtask

  task automatic start_dump();
    seen_q.delete();
    done_cnt = 0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic finish_dump(input int mode);
    int k = 0;
    bit rdy;
    while (m_mode == M_DUMP && k < 60) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom);
      cycle(1'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'($urandom), rdy);
      k++;
    end
    check("seen_n", seen_q.size(), N + 1);
    for (int i = 0; i < seen_q.size(); i++) check("seen_idx", seen_q[i], i);
    check("done_n", done_cnt, 1);
  endtask

  task automatic run_dump(input int mode);
    start_dump();
    finish_dump(mode);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_clear();
    do_reset();

    // Plain counting with a fixed event pattern.
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_dump(0);

    // Enable gating.
    cycle(1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    start_dump();
    check("gate_data0", out_data_s, 4);
    finish_dump(0);

    // Saturate vs wrap on 300 events.
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_dump();
    check("sat_data", out_data_s, 255);
    check("wrap_data", out_data_w, 44);
    check("sat_ovf", out_ovf_s, 1);
    check("wrap_ovf", out_ovf_w, 1);
    finish_dump(0);

    // Backpressure re-dump of the same frozen counts.
    run_dump(1);

    // Ignored inputs while frozen.
    for (int i = 0; i < 10; i++)
      cycle(1'($urandom), N'($urandom), 1'b1, 1'b0, 1'b0, 1'($urandom));
    run_dump(2);

    // dump_start in RUN is ignored.
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, N'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    check("run_dump_valid", out_valid_s, 0);

    // clr wins over halt.
    cycle(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_halt_frozen", frozen_s, 0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_dump(0);

    // clr in the middle of a dump.
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, N'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, N'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    start_dump();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_idx", out_idx_s, 2);
    d0 = done_cnt;
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_valid", out_valid_s, 0);
    check("clr_frozen", frozen_s, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_no_done", done_cnt, d0);

    // Reset in the middle of a dump.
    for (int i = 0; i < 5; i++) cycle(1'b1, N'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, N'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    start_dump();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom), N'($urandom), ($urandom % 20) == 0, ($urandom % 80) == 0,
            ($urandom % 6) == 0, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable performance-event counter bank that replaces bench-only hierarchical counting of retired instructions and I/D-cache requests and hits. It sits beside the pipeline in the processor hierarchy, counts up to NUM_EVT single-bit event strobes plus a cycle counter, and freezes all counts when the processor halts. The frozen counts are then streamed out one entry at a time over a valid/ready port for logging.

## Interface
- NUM_EVT, 8, number of event channels (1..16)
- CNT_W, 32, counter width in bits (8..64)
- SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- en  in  1  count enable; events and cycles are counted only while en=1
- evt  in  NUM_EVT  per-channel event strobes, one count per cycle when high
- halt  in  1  processor-halt strobe; freezes the bank
- clr  in  1  soft clear; zeroes all counts and returns the bank to RUN
- dump_start  in  1  starts a readout; accepted only in FROZEN
- out_valid  out  1  readout entry valid
- out_ready  in  1  consumer accepts the entry
- out_idx  out  $clog2(NUM_EVT+1)  entry index; NUM_EVT = cycle counter
- out_data  out  CNT_W  entry count
- out_ovf  out  1  sticky overflow flag of the entry
- frozen  out  1  high in FROZEN and DUMP
- dump_done  out  1  one-cycle pulse after the last entry is accepted

## Operation
- States: RUN, FROZEN, DUMP. Reset enters RUN.
- RUN:
  - Counter i increments when en & evt[i]; the cycle counter increments when en.
  - halt=1 moves the bank to FROZEN. Events and the cycle in the halt cycle are still counted, so the halting instruction is included.
- FROZEN:
  - Counts hold.
  - dump_start=1 moves the bank to DUMP with index 0.
  - halt, evt and en are ignored.
- DUMP:
  - out_valid=1 with out_idx = index, out_data = count[index], out_ovf = ovf[index].
  - Handshake on out_valid & out_ready: index increments. out_idx, out_data and out_ovf stay stable while out_ready=0.
  - Accepting index NUM_EVT returns the bank to FROZEN and pulses dump_done.
  - dump_start and halt are ignored.
- Arithmetic:
  - On the increment from all-ones, ovf[i] sets and stays set until clr or reset.
  - SAT=1: the count stays at 2^CNT_W-1. SAT=0: the count becomes 0.
- clr, in any state:
  - Next cycle: all counts and ovf flags are 0, state is RUN, out_valid=0.
  - An in-flight dump is aborted with no dump_done.
- Priority: reset > clr > halt/dump_start > counting.

## Timing
- Reset values: all counts 0, all ovf 0, state RUN, out_valid 0, out_idx 0, out_data 0, out_ovf 0, frozen 0, dump_done 0.
- Count latency: an event in cycle t is visible in the count at cycle t+1.
- halt sampled at edge t gives frozen=1 from t+1.
- dump_start sampled at edge t gives out_valid=1 with index 0 from t+1.
- A full dump with out_ready held high takes NUM_EVT+1 cycles. dump_done is high in the cycle after the final accept, when frozen is still 1.
- All outputs are registered. There is no combinational path from in to out.

## Structure
- Package perf_pkg:
  - state enum {RUN, FROZEN, DUMP}
  - IDX_W = $clog2(NUM_EVT+1) helper
- Sub-module perf_ctr: a CNT_W counter with inc, clr, SAT mode and sticky ovf. It is instantiated NUM_EVT+1 times, once per event channel plus once for the cycle counter.
- The top level holds the FSM, the dump index register and the output mux/register.

## Test plan
- Counting: NUM_EVT=4, en=1, evt=4'b0101 for 10 cycles, then halt. Dump gives idx0=10, idx1=0, idx2=10, idx3=0, idx4 (cycles)=11, all ovf=0.
- Enable gating: en=0 for 5 cycles with evt=all-ones, then en=1 for 3 cycles, then halt. Every channel and the cycle counter read 4.
- Saturate vs wrap: CNT_W=8, 300 events on channel 0.
  - SAT=1: out_data=255, out_ovf=1.
  - SAT=0: out_data=44, out_ovf=1.
- Backpressure: during a dump, toggle out_ready 1,0,0,1,...
  - out_idx and out_data stay stable while out_ready=0.
  - Indices appear in order 0..NUM_EVT exactly once.
  - dump_done fires once.
- Clear and priority:
  - clr together with halt: the next cycle is RUN with counts 0.
  - clr mid-dump at idx 2: out_valid drops, no dump_done, frozen=0.
  - Reset (rst=0) mid-dump: every output takes its reset value.
- Ignored inputs:
  - dump_start in RUN leaves out_valid=0.
  - A second halt in FROZEN or evt activity in FROZEN leaves counts unchanged.
